// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one combinational ALU between two requesters.
// A round-robin arbiter accepts one operation at a time, drives the ALU from
// latched operands, captures the result and flags, and returns them on a
// valid/ready response channel.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req{0,1}_valid/_ready          request handshake (ready is combinational)
//   req{0,1}_A/_B/_opcode          request payload
//   alu_A/alu_B/alu_opcode         to the ALU, from latched registers
//   alu_result/alu_flags           from the ALU ({V,C,Z,P})
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_result/rsp_flags    response payload
//   busy                           operation in flight (EXEC or RESP)
//   op_cnt                         completed responses, wrapping
module alu_req_arbiter #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [DATA_WIDTH-1:0]   req0_A,
    input  logic [DATA_WIDTH-1:0]   req0_B,
    input  logic [OPCODE_WIDTH-1:0] req0_opcode,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [DATA_WIDTH-1:0]   req1_A,
    input  logic [DATA_WIDTH-1:0]   req1_B,
    input  logic [OPCODE_WIDTH-1:0] req1_opcode,
    output logic [DATA_WIDTH-1:0]   alu_A,
    output logic [DATA_WIDTH-1:0]   alu_B,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic [3:0]              alu_flags,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic [3:0]              rsp_flags,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    op_cnt
);

    localparam int unsigned FLAG_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic                    id_q, id_d;
    logic                    last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [FLAG_WIDTH-1:0]   flags_q, flags_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    grant_id;
    logic                    any_valid;

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        flags_d      = flags_q;
        cnt_d        = cnt_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Ready goes only to a valid winner, so any valid means accept.
                if (any_valid) begin
                    req0_ready   = ~grant_id;
                    req1_ready   = grant_id;
                    a_d          = grant_id ? req1_A : req0_A;
                    b_d          = grant_id ? req1_B : req0_B;
                    op_d         = grant_id ? req1_opcode : req0_opcode;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                flags_d  = alu_flags;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            flags_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            cnt_q        <= cnt_d;
        end
    end

    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_opcode = op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign busy       = (state_q != ST_IDLE);
    assign op_cnt     = cnt_q;

endmodule
